// File: rtl/dmem_arbiter_pkg.sv
// Shared widths, requester IDs and the read-return tag type for the data-memory arbiter.
// Imported by the arbiter top and its tag pipeline.
package dmem_arbiter_pkg;

    localparam int DMEM_ADDR_WIDTH = 32;
    localparam int DMEM_DATA_WIDTH = 32;
    localparam int DMEM_RD_LATENCY = 1;

    typedef enum logic {
        DMEM_REQ_CORE = 1'b0,
        DMEM_REQ_AUX  = 1'b1
    } dmem_req_e;

    typedef struct packed {
        logic      valid;
        dmem_req_e owner;
    } dmem_tag_t;

endpackage

// File: rtl/dmem_tag_pipe.sv
// Fixed-depth shift register of {valid, owner} tags that follows reads through the memory.
// Shifts every cycle and never stalls.
module dmem_tag_pipe
    import dmem_arbiter_pkg::*;
#(
    parameter int DEPTH = DMEM_RD_LATENCY
) (
    input  logic      clk,
    input  logic      rst_n,
    input  dmem_tag_t tag_in,
    output dmem_tag_t tag_out
);

    dmem_tag_t stage_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every stage is cleared, because a stale valid bit would fire a spurious rvalid after reset.
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: grants one access per cycle, registers it onto mem_*,
// and routes read data back to the requester that issued the read.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DMEM_ADDR_WIDTH,
    parameter int DATA_W     = DMEM_DATA_WIDTH,
    parameter int RD_LATENCY = DMEM_RD_LATENCY,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_req,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic              r0_we,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic              r1_we,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wenable,
    output logic [DATA_W-1:0] mem_wvalue,
    input  logic [DATA_W-1:0] mem_rvalue
);

    dmem_req_e         last_q;
    dmem_req_e         winner;
    logic              any_gnt;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_we;
    logic [DATA_W-1:0] sel_wdata;
    dmem_tag_t         cmd_tag_q;
    dmem_tag_t         ret_tag;

    always_comb begin
        // NOTE: both grants get a default before any branch, so no path leaves them unassigned (no latch).
        r0_gnt = 1'b0;
        r1_gnt = 1'b0;
        if (rst_n) begin
            if (r0_req && r1_req) begin
                if ((FIXED_PRIO != 0) || (last_q == DMEM_REQ_AUX)) begin
                    r0_gnt = 1'b1;
                end else begin
                    r1_gnt = 1'b1;
                end
            end else begin
                r0_gnt = r0_req;
                r1_gnt = r1_req;
            end
        end
    end

    assign any_gnt   = r0_gnt | r1_gnt;
    assign winner    = r1_gnt ? DMEM_REQ_AUX : DMEM_REQ_CORE;
    assign sel_addr  = r1_gnt ? r1_addr  : r0_addr;
    assign sel_we    = r1_gnt ? r1_we    : r0_we;
    assign sel_wdata = r1_gnt ? r1_wdata : r0_wdata;

    // The command tag sits beside mem_*, so the tag pipe output lines up with mem_rvalue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q      <= DMEM_REQ_AUX;
            mem_addr    <= '0;
            mem_wenable <= 1'b0;
            mem_wvalue  <= '0;
            cmd_tag_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every register here samples pre-edge values.
            mem_wenable <= any_gnt && sel_we;
            cmd_tag_q   <= '{valid: any_gnt && !sel_we, owner: winner};
            if (any_gnt) begin
                last_q     <= winner;
                mem_addr   <= sel_addr;
                mem_wvalue <= sel_wdata;
            end
        end
    end

    dmem_tag_pipe #(
        .DEPTH (RD_LATENCY)
    ) u_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .tag_in  (cmd_tag_q),
        .tag_out (ret_tag)
    );

    assign r0_rvalid = ret_tag.valid && (ret_tag.owner == DMEM_REQ_CORE);
    assign r1_rvalid = ret_tag.valid && (ret_tag.owner == DMEM_REQ_AUX);
    assign r0_rdata  = r0_rvalid ? mem_rvalue : '0;
    assign r1_rdata  = r1_rvalid ? mem_rvalue : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: round-robin/latency-1, fixed-priority and latency-3
// instances share one stimulus; a small memory model answers reads.
module tb_dmem_arbiter;

    localparam logic        H = 1'b1;
    localparam logic        L = 1'b0;
    localparam logic [31:0] Z = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        r0_req = 1'b0, r0_we = 1'b0, r1_req = 1'b0, r1_we = 1'b0;
    logic [31:0] r0_addr = '0, r0_wdata = '0, r1_addr = '0, r1_wdata = '0;

    logic        rr_r0_gnt, rr_r0_rvalid, rr_r1_gnt, rr_r1_rvalid, rr_mem_wenable;
    logic [31:0] rr_r0_rdata, rr_r1_rdata, rr_mem_addr, rr_mem_wvalue, rr_mem_rvalue;
    logic        fp_r0_gnt, fp_r0_rvalid, fp_r1_gnt, fp_r1_rvalid, fp_mem_wenable;
    logic [31:0] fp_r0_rdata, fp_r1_rdata, fp_mem_addr, fp_mem_wvalue;
    logic        l3_r0_gnt, l3_r0_rvalid, l3_r1_gnt, l3_r1_rvalid, l3_mem_wenable;
    logic [31:0] l3_r0_rdata, l3_r1_rdata, l3_mem_addr, l3_mem_wvalue, l3_mem_rvalue;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(1), .FIXED_PRIO(0)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req), .r0_addr(r0_addr), .r0_we(r0_we), .r0_wdata(r0_wdata),
        .r0_gnt(rr_r0_gnt), .r0_rvalid(rr_r0_rvalid), .r0_rdata(rr_r0_rdata),
        .r1_req(r1_req), .r1_addr(r1_addr), .r1_we(r1_we), .r1_wdata(r1_wdata),
        .r1_gnt(rr_r1_gnt), .r1_rvalid(rr_r1_rvalid), .r1_rdata(rr_r1_rdata),
        .mem_addr(rr_mem_addr), .mem_wenable(rr_mem_wenable), .mem_wvalue(rr_mem_wvalue),
        .mem_rvalue(rr_mem_rvalue));

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(1), .FIXED_PRIO(1)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req), .r0_addr(r0_addr), .r0_we(r0_we), .r0_wdata(r0_wdata),
        .r0_gnt(fp_r0_gnt), .r0_rvalid(fp_r0_rvalid), .r0_rdata(fp_r0_rdata),
        .r1_req(r1_req), .r1_addr(r1_addr), .r1_we(r1_we), .r1_wdata(r1_wdata),
        .r1_gnt(fp_r1_gnt), .r1_rvalid(fp_r1_rvalid), .r1_rdata(fp_r1_rdata),
        .mem_addr(fp_mem_addr), .mem_wenable(fp_mem_wenable), .mem_wvalue(fp_mem_wvalue),
        .mem_rvalue(Z));

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(3), .FIXED_PRIO(0)) u_l3 (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req), .r0_addr(r0_addr), .r0_we(r0_we), .r0_wdata(r0_wdata),
        .r0_gnt(l3_r0_gnt), .r0_rvalid(l3_r0_rvalid), .r0_rdata(l3_r0_rdata),
        .r1_req(r1_req), .r1_addr(r1_addr), .r1_we(r1_we), .r1_wdata(r1_wdata),
        .r1_gnt(l3_r1_gnt), .r1_rvalid(l3_r1_rvalid), .r1_rdata(l3_r1_rdata),
        .mem_addr(l3_mem_addr), .mem_wenable(l3_mem_wenable), .mem_wvalue(l3_mem_wvalue),
        .mem_rvalue(l3_mem_rvalue));

    // Memory model: rr and l3 see identical stimulus and grant identically, so rr's writes update it.
    logic [31:0] mem [256];
    logic [31:0] dl1;
    logic [31:0] dl3 [3];

    always @(posedge clk) begin
        dl1    <= mem[rr_mem_addr[7:0]];
        dl3[0] <= mem[l3_mem_addr[7:0]];
        dl3[1] <= dl3[0];
        dl3[2] <= dl3[1];
        if (rr_mem_wenable) mem[rr_mem_addr[7:0]] <= rr_mem_wvalue;
    end

    assign rr_mem_rvalue = dl1;
    assign l3_mem_rvalue = dl3[2];

    typedef struct {
        logic q0; logic w0; logic [31:0] a0; logic [31:0] d0;
        logic q1; logic w1; logic [31:0] a1; logic [31:0] d1;
        logic g0; logic g1; logic mwe; logic [31:0] maddr;
        logic v0; logic [31:0] rd0; logic v1; logic [31:0] rd1;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic q0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                         input logic q1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
        r0_req = q0; r0_we = w0; r0_addr = a0; r0_wdata = d0;
        r1_req = q1; r1_we = w1; r1_addr = a1; r1_wdata = d1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(L, L, Z, Z, L, L, Z, Z);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t vecs [14];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset state, with both requests raised to show grants are suppressed.
        drive(H, H, 32'h44, 32'h99, H, H, 32'h45, 32'h98);
        @(negedge clk);
        @(negedge clk);
        check("reset_rr_gnt", {rr_r0_gnt, rr_r1_gnt}, Z);
        check("reset_fp_gnt", {fp_r0_gnt, fp_r1_gnt}, Z);
        check("reset_mem_addr", rr_mem_addr, Z);
        check("reset_mem_we", rr_mem_wenable, Z);
        check("reset_mem_wvalue", rr_mem_wvalue, Z);
        check("reset_rvalid", {rr_r0_rvalid, rr_r1_rvalid, l3_r0_rvalid, l3_r1_rvalid}, Z);
        check("reset_rdata", rr_r0_rdata | rr_r1_rdata, Z);
        drive(L, L, Z, Z, L, L, Z, Z);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table on the round-robin, latency-1 instance, starting right after reset.
        vecs[0]  = '{H, H, 32'h10, 32'hDEADBEEF, L, L, Z, Z, H, L, L, Z, L, Z, L, Z};
        vecs[1]  = '{H, L, 32'h10, Z, L, L, Z, Z, H, L, H, 32'h10, L, Z, L, Z};
        vecs[2]  = '{L, L, Z, Z, L, L, Z, Z, L, L, L, 32'h10, L, Z, L, Z};
        vecs[3]  = '{L, L, Z, Z, H, H, 32'h11, 32'h12345678, L, H, L, 32'h10, H, 32'hDEADBEEF, L, Z};
        vecs[4]  = '{H, L, 32'h11, Z, H, L, 32'h10, Z, H, L, H, 32'h11, L, Z, L, Z};
        vecs[5]  = '{L, L, Z, Z, H, L, 32'h10, Z, L, H, L, 32'h11, L, Z, L, Z};
        vecs[6]  = '{H, H, 32'h12, 32'hA5A5A5A5, H, H, 32'h13, 32'h5A5A5A5A, H, L, L, 32'h10, H, 32'h12345678, L, Z};
        vecs[7]  = '{L, L, Z, Z, H, H, 32'h13, 32'h5A5A5A5A, L, H, H, 32'h12, L, Z, H, 32'hDEADBEEF};
        vecs[8]  = '{L, L, Z, Z, L, L, Z, Z, L, L, H, 32'h13, L, Z, L, Z};
        vecs[9]  = '{L, L, Z, Z, L, L, Z, Z, L, L, L, 32'h13, L, Z, L, Z};
        vecs[10] = '{H, L, 32'h13, Z, H, L, 32'h12, Z, H, L, L, 32'h13, L, Z, L, Z};
        vecs[11] = '{L, L, Z, Z, H, L, 32'h12, Z, L, H, L, 32'h13, L, Z, L, Z};
        vecs[12] = '{L, L, Z, Z, L, L, Z, Z, L, L, L, 32'h12, H, 32'h5A5A5A5A, L, Z};
        vecs[13] = '{L, L, Z, Z, L, L, Z, Z, L, L, L, 32'h12, L, Z, H, 32'hA5A5A5A5};

        for (int i = 0; i < 14; i++) begin
            next_cycle();
            drive(vecs[i].q0, vecs[i].w0, vecs[i].a0, vecs[i].d0,
                  vecs[i].q1, vecs[i].w1, vecs[i].a1, vecs[i].d1);
            @(negedge clk);
            check($sformatf("vec%0d_gnt", i), {rr_r0_gnt, rr_r1_gnt}, {vecs[i].g0, vecs[i].g1});
            check($sformatf("vec%0d_mem_we", i), rr_mem_wenable, vecs[i].mwe);
            check($sformatf("vec%0d_mem_addr", i), rr_mem_addr, vecs[i].maddr);
            check($sformatf("vec%0d_rvalid", i), {rr_r0_rvalid, rr_r1_rvalid}, {vecs[i].v0, vecs[i].v1});
            check($sformatf("vec%0d_r0_rdata", i), rr_r0_rdata, vecs[i].rd0);
            check($sformatf("vec%0d_r1_rdata", i), rr_r1_rdata, vecs[i].rd1);
        end

        // Continuous contention from reset: rr alternates r0,r1; fixed priority keeps r0.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            drive(i < 4 ? H : L, L, 32'h10, Z, H, L, 32'h11, Z);
            @(negedge clk);
            check($sformatf("rr_contend%0d", i), {rr_r0_gnt, rr_r1_gnt},
                  (i == 4) ? 32'h1 : ((i % 2 == 0) ? 32'h2 : 32'h1));
            check($sformatf("rr_onehot%0d", i), rr_r0_gnt & rr_r1_gnt, Z);
            check($sformatf("fp_contend%0d", i), {fp_r0_gnt, fp_r1_gnt}, (i == 4) ? 32'h1 : 32'h2);
        end
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            drive(L, L, Z, Z, L, L, Z, Z);
        end

        // Latency-3 sweep: preload 0x20/0x21 through the port, then r1 reads 0x20, r0 reads 0x21.
        next_cycle(); drive(H, H, 32'h20, 32'h55, L, L, Z, Z);
        next_cycle(); drive(H, H, 32'h21, 32'hAA, L, L, Z, Z);
        next_cycle(); drive(L, L, Z, Z, L, L, Z, Z);
        next_cycle(); drive(L, L, Z, Z, H, L, 32'h20, Z);
        @(negedge clk);
        check("l3_r1_gnt", {l3_r0_gnt, l3_r1_gnt}, 32'h1);
        next_cycle(); drive(H, L, 32'h21, Z, L, L, Z, Z);
        @(negedge clk);
        check("l3_r0_gnt", {l3_r0_gnt, l3_r1_gnt}, 32'h2);
        for (int t = 2; t <= 5; t++) begin
            next_cycle();
            drive(L, L, Z, Z, L, L, Z, Z);
            @(negedge clk);
            check($sformatf("l3_T%0d_rvalid", t), {l3_r0_rvalid, l3_r1_rvalid},
                  (t == 4) ? 32'h1 : ((t == 5) ? 32'h2 : 32'h0));
            check($sformatf("l3_T%0d_r0_rdata", t), l3_r0_rdata, (t == 5) ? 32'hAA : Z);
            check($sformatf("l3_T%0d_r1_rdata", t), l3_r1_rdata, (t == 4) ? 32'h55 : Z);
        end

        // Idle hold after a write to 0x30.
        next_cycle(); drive(H, H, 32'h30, 32'h77, L, L, Z, Z);
        next_cycle(); drive(L, L, Z, Z, L, L, Z, Z);
        @(negedge clk);
        check("idle_write_we", rr_mem_wenable, 32'h1);
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            @(negedge clk);
            check($sformatf("idle%0d_we", i), rr_mem_wenable, Z);
            check($sformatf("idle%0d_addr", i), rr_mem_addr, 32'h30);
            check($sformatf("idle%0d_rvalid", i), {rr_r0_rvalid, rr_r1_rvalid}, Z);
        end

        // Reset mid-read: r0 read granted, reset asserted the next cycle; no return ever appears.
        next_cycle(); drive(H, L, 32'h10, Z, L, L, Z, Z);
        @(negedge clk);
        check("midrst_gnt", rr_r0_gnt, 32'h1);
        next_cycle();
        drive(L, L, Z, Z, L, L, Z, Z);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_mem_we", rr_mem_wenable, Z);
        check("midrst_mem_addr", rr_mem_addr, Z);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 5; i++) begin
                next_cycle();
                @(negedge clk);
                seen = seen | rr_r0_rvalid | l3_r0_rvalid;
            end
            check("midrst_no_rvalid", seen, Z);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters: requester 0 is the core load/store stage, requester 1 is the debug/DMA loader.
- Arbitrates one access per cycle, either round-robin or fixed-priority, and registers the winning command onto the memory port.
- Tracks outstanding reads in a tag pipeline and returns read data with a valid strobe to the requester that issued it.
- Sits between the requesters and the memory-accesser path that drives the data memory.

Parameters:
- ADDR_W, `DMEM_ADDR_WIDTH, address width.
- DATA_W, `DMEM_DATA_WIDTH, data width.
- RD_LATENCY, 1, cycles from command on mem_* to valid mem_rvalue (legal range 1..4).
- FIXED_PRIO, 0, 0 = round-robin; 1 = requester 0 always wins.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- r0_req  input  1  requester 0 access request; held with its command until granted.
- r0_addr  input  ADDR_W  requester 0 address.
- r0_we  input  1  requester 0 write enable (1 = write, 0 = read).
- r0_wdata  input  DATA_W  requester 0 write data.
- r0_gnt  output  1  command accepted this cycle (combinational).
- r0_rvalid  output  1  read data valid for requester 0.
- r0_rdata  output  DATA_W  read data for requester 0.
- r1_req, r1_addr, r1_we, r1_wdata, r1_gnt, r1_rvalid, r1_rdata  same as r0_*, for requester 1.
- mem_addr  output  ADDR_W  registered memory address.
- mem_wenable  output  1  registered memory write enable.
- mem_wvalue  output  DATA_W  registered memory write data.
- mem_rvalue  input  DATA_W  memory read data, RD_LATENCY cycles after the command.

Behaviour:
- Clocking: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values (while rst_n=0): mem_addr=0, mem_wenable=0, mem_wvalue=0; r0_gnt=r1_gnt=0; r0_rvalid=r1_rvalid=0; r*_rdata=0. Round-robin pointer last=1, so requester 0 wins the first contention.
- Grant (combinational, cycle T):
  - Only one req high: that requester is granted.
  - Both high, FIXED_PRIO=0: grant the requester that is not last; last updates to the winner at the T edge.
  - Both high, FIXED_PRIO=1: requester 0 wins.
  - Neither high: no grant; last unchanged.
  - At most one gnt is high per cycle.
- Handshake:
  - A requester keeps req, addr, we and wdata stable until it samples gnt=1.
  - req may drop only after gnt. Dropping req while ungranted is legal and discards the request with no side effects.
  - Back-to-back grants to the same requester are allowed.
- Command issue (cycle T+1): mem_addr, mem_wenable and mem_wvalue register the granted command.
  - With no grant: mem_wenable=0; mem_addr and mem_wvalue hold their previous values.
  - A write completes on the memory side at T+1; no rvalid is produced for it.
- Read return:
  - A tag pipeline of depth RD_LATENCY carries {valid, owner}; writes enter as valid=0.
  - At cycle T+1+RD_LATENCY, rX_rvalid=1 for exactly one cycle for the owning requester.
  - rX_rdata = mem_rvalue passed combinationally when valid, and 0 otherwise.
- Throughput and fairness: one command per cycle sustained. In round-robin mode, a requester holding req is granted within 2 cycles.
- Ordering: per-requester returns come back in issue order. A read after a write to the same address (same or other requester) returns the written data, because the memory port serialises.
- Reset mid-operation: all in-flight tags are cleared, pending reads never assert rvalid, and the mem_* outputs go to their reset values immediately (async).
- Pipeline entry: req and grant in the same cycle as a tag exiting is legal. The tag pipeline shifts every cycle and never stalls.

Decomposition:
- Shared package / config.inc.v:
  - reuse `DMEM_ADDR_WIDTH and `DMEM_DATA_WIDTH.
  - add `DMEM_RD_LATENCY (default 1).
  - add requester ID constants `DMEM_REQ_CORE=0 and `DMEM_REQ_AUX=1.
- One natural sub-module: dmem_tag_pipe, a parameterised RD_LATENCY-deep shift register of {valid, owner} with asynchronous active-low clear.

Test Plan:
- Reset mid-read: r0 read granted at T, rst_n low at T+1 -> no r0_rvalid ever; mem_wenable=0 and mem_addr=0 during reset.
- Single write then read: r0 write addr 0x10 data 0xDEADBEEF at T, r0 read 0x10 at T+1 -> mem_wenable=1 at T+1; r0_rvalid=1, r0_rdata=0xDEADBEEF at T+3 (RD_LATENCY=1).
- Contention, round-robin: both request continuously from reset -> grants alternate r0, r1, r0, r1; never two gnt in one cycle.
- Fixed priority: FIXED_PRIO=1, both request for 4 cycles -> r0_gnt=1 all 4 cycles, r1_gnt=0; r1 granted the cycle r0 drops req.
- Latency sweep: RD_LATENCY=3, r1 reads 0x20 (memory holds 0x55) then r0 reads 0x21 (memory holds 0xAA) -> r1_rvalid with 0x55 at T+4, r0_rvalid with 0xAA at T+5, with no cross-routing.
- Idle hold: no requests for 5 cycles after a write to 0x30 -> mem_wenable=0 throughout; mem_addr stays 0x30; no rvalid.
